// File: rtl/linea_retardo.sv
// linea_retardo: input stage of the FIR datapath.
//  - Detects the rising edge of clk_lento, which is synchronous to clk_medio.
//  - On each such tick, shifts one audio sample into a TAPS-deep delay line.
//  - Streams the delay line, newest first, over a valid/ready port.
//
// Ports:
//  clk_medio    in   system clock; all logic is on its rising edge
//  reset_n      in   asynchronous active-low reset
//  clk_lento    in   sample clock, synchronous to clk_medio
//  muestra_in   in   ANCHO-bit sample, valid in the cycle clk_lento rises
//  tap_ready    in   MAC stage accepts the current tap
//  clr_overrun  in   synchronous clear of the overrun flag
//  tap_out      out  linea[tap_idx]
//  tap_idx      out  tap index, 0 = newest sample
//  tap_valid    out  tap_out/tap_idx valid
//  tap_last     out  beat carrying tap_idx == TAPS-1
//  overrun      out  sticky: a tick arrived while a read-out was in progress
//
// Handshake: a beat happens in every cycle where tap_valid and tap_ready are
// both high. While tap_valid is high and tap_ready is low, tap_idx, tap_out
// and tap_valid hold, and the delay line is frozen.
//
// The FSM state is held in state_q (IDLE / LECTURA) and is mirrored directly
// on tap_valid.

module linea_retardo #(
  parameter int ANCHO = 16,
  parameter int TAPS  = 8,
  parameter int AW    = 3
) (
  input  logic             clk_medio,
  input  logic             reset_n,
  input  logic             clk_lento,
  input  logic [ANCHO-1:0] muestra_in,
  input  logic             tap_ready,
  input  logic             clr_overrun,
  output logic [ANCHO-1:0] tap_out,
  output logic [AW-1:0]    tap_idx,
  output logic             tap_valid,
  output logic             tap_last,
  output logic             overrun
);

  typedef enum logic {
    IDLE    = 1'b0,
    LECTURA = 1'b1
  } estado_t;

  localparam logic [AW-1:0] IDX_LAST = AW'(TAPS - 1);

  estado_t          state_q, state_d;
  logic             lento_q, lento_d;
  logic [ANCHO-1:0] linea_q [TAPS];
  logic [ANCHO-1:0] linea_d [TAPS];
  logic [AW-1:0]    idx_q, idx_d;
  logic             overrun_q, overrun_d;

  logic tick;
  logic beat;
  logic beat_ultimo;
  logic shift;
  logic set_ovr;

  // Outputs come straight from registered state.
  assign tap_valid = (state_q == LECTURA);
  assign tap_idx   = idx_q;
  assign tap_out   = linea_q[idx_q];
  assign tap_last  = tap_valid & (idx_q == IDX_LAST);
  assign overrun   = overrun_q;

  always_comb begin
    lento_d     = clk_lento;
    tick        = clk_lento & ~lento_q;
    beat        = tap_valid & tap_ready;
    beat_ultimo = beat & (idx_q == IDX_LAST);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift   = 1'b0;
    set_ovr = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          shift   = 1'b1;
          idx_d   = '0;
          state_d = LECTURA;
        end
      end
      LECTURA: begin
        if (beat_ultimo) begin
          if (tick) begin
            // A tick landing on the final beat starts the next read-out
            // back-to-back: this is the continuous-streaming case.
            shift = 1'b1;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (beat) begin
            idx_d = idx_q + AW'(1);
          end
          // Tick while the read-out is unfinished: the sample is dropped.
          if (tick) begin
            set_ovr = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Delay line: shift in the new sample, oldest word falls off the end.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      linea_d[k] = linea_q[k];
    end
    if (shift) begin
      linea_d[0] = muestra_in;
      for (int k = 1; k < TAPS; k++) begin
        linea_d[k] = linea_q[k-1];
      end
    end
  end

  // Set has priority over clear.
  always_comb begin
    overrun_d = overrun_q;
    if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    if (set_ovr) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_medio or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      // Reset to 1 so a clk_lento already high at release is not a tick.
      lento_q   <= 1'b1;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        linea_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      lento_q   <= lento_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      for (int k = 0; k < TAPS; k++) begin
        linea_q[k] <= linea_d[k];
      end
    end
  end

endmodule

// File: tb/tb_linea_retardo.sv
// Testbench for linea_retardo: directed scenarios followed by randomized
// sample periods, checked against a queue-based sample-history model.

module tb_linea_retardo;

  localparam int ANCHO = 16;
  localparam int TAPS  = 8;
  localparam int AW    = 3;

  // ---------------- clock / reset ----------------
  logic             clk_medio = 1'b0;
  logic             reset_n;
  logic             clk_lento;
  logic [ANCHO-1:0] muestra_in;
  logic             tap_ready;
  logic             clr_overrun;
  logic [ANCHO-1:0] tap_out;
  logic [AW-1:0]    tap_idx;
  logic             tap_valid;
  logic             tap_last;
  logic             overrun;

  always #5 clk_medio = ~clk_medio;

  linea_retardo #(.ANCHO(ANCHO), .TAPS(TAPS), .AW(AW)) dut (
    .clk_medio  (clk_medio),
    .reset_n    (reset_n),
    .clk_lento  (clk_lento),
    .muestra_in (muestra_in),
    .tap_ready  (tap_ready),
    .clr_overrun(clr_overrun),
    .tap_out    (tap_out),
    .tap_idx    (tap_idx),
    .tap_valid  (tap_valid),
    .tap_last   (tap_last),
    .overrun    (overrun)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  // hist[0] is the newest accepted sample; always TAPS entries.
  logic [ANCHO-1:0] hist[$];
  bit  m_reading;
  int  m_pos;
  bit  m_ovf;
  bit  m_lento_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < TAPS; i++) hist.push_back('0);
    m_reading    = 1'b0;
    m_pos        = 0;
    m_ovf        = 1'b0;
    m_lento_prev = 1'b1;
  endtask

  task automatic accept(input logic [ANCHO-1:0] m);
    hist.push_front(m);
    void'(hist.pop_back());
    m_pos     = 0;
    m_reading = 1'b1;
  endtask

  // Advance the model by one clock given this cycle's inputs.
  task automatic model_step(input logic lento, input logic [ANCHO-1:0] m,
                            input logic rdy, input logic clr);
    bit tick, beat, fin, drop;
    tick = lento && !m_lento_prev;
    m_lento_prev = lento;
    beat = m_reading && rdy;
    fin  = beat && (m_pos == TAPS - 1);
    drop = m_reading && tick && !fin;
    if (!m_reading) begin
      if (tick) accept(m);
    end else if (fin) begin
      if (tick) accept(m);
      else m_reading = 1'b0;
    end else if (beat) begin
      m_pos++;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_outs();
    chk("tap_valid", {31'b0, tap_valid}, {31'b0, m_reading});
    chk("tap_last", {31'b0, tap_last}, {31'b0, (m_reading && m_pos == TAPS - 1)});
    chk("overrun", {31'b0, overrun}, {31'b0, m_ovf});
    if (m_reading) begin
      chk("tap_idx", {29'b0, tap_idx}, m_pos);
      chk("tap_out", {16'b0, tap_out}, {16'b0, hist[m_pos]});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge: check outputs, drive inputs, clock once.
  task automatic cyc(input logic lento, input logic [ANCHO-1:0] m,
                     input logic rdy, input logic clr);
    check_outs();
    clk_lento   = lento;
    muestra_in  = m;
    tap_ready   = rdy;
    clr_overrun = clr;
    model_step(lento, m, rdy, clr);
    @(posedge clk_medio);
    @(negedge clk_medio);
  endtask

  // One sample period: clk_lento high for the first half, low for the rest.
  task automatic periodo(input logic [ANCHO-1:0] m, input int len,
                         input int rdy_pct, input bit clr_rand);
    for (int i = 0; i < len; i++) begin
      cyc(i < len / 2, m, $urandom_range(0, 99) < rdy_pct,
          clr_rand && ($urandom_range(0, 7) == 0));
    end
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", {31'b0, tap_valid}, 32'd0);
    chk("rst_last", {31'b0, tap_last}, 32'd0);
    chk("rst_ovr", {31'b0, overrun}, 32'd0);
    chk("rst_idx", {29'b0, tap_idx}, 32'd0);
    clk_lento   = 1'b1;
    tap_ready   = 1'b1;
    clr_overrun = 1'b0;
    @(negedge clk_medio);
    @(negedge clk_medio);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ANCHO-1:0] held;
    reset_n     = 1'b0;
    clk_lento   = 1'b1;
    muestra_in  = '0;
    tap_ready   = 1'b1;
    clr_overrun = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_medio);
    chk("init_valid", {31'b0, tap_valid}, 32'd0);
    chk("init_idx", {29'b0, tap_idx}, 32'd0);
    reset_n = 1'b1;

    // T1: clk_lento high at release gives no tick.
    repeat (5) cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("t1_no_tick", {31'b0, tap_valid}, 32'd0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // T2: impulse, then zeros; the impulse walks one tap per read-out.
    periodo(16'h7FFF, 8, 100, 1'b0);
    for (int n = 0; n < 8; n++) periodo(16'h0000, 8, 100, 1'b0);

    // T3: hold tap_ready low three cycles while tap_idx is 2.
    for (int i = 0; i < 12; i++) begin
      if (i == 3) held = tap_out;
      if (i >= 3 && i <= 6) begin
        chk("t3_idx_hold", {29'b0, tap_idx}, 32'd2);
        chk("t3_out_hold", {16'b0, tap_out}, {16'b0, held});
      end
      cyc(i < 6, 16'h00C3, !(i >= 3 && i <= 5), 1'b0);
    end

    // T4: ramp 1..20 at full rate; each tick lands on tap_last.
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) chk("t4_tick_on_last", {31'b0, tap_last}, 32'd1);
      periodo(ANCHO'(k), 8, 100, 1'b0);
    end
    chk("t4_no_ovr", {31'b0, overrun}, 32'd0);

    // T5: stalled MAC across sample periods -> dropped samples, overrun.
    periodo(16'h5555, 8, 0, 1'b0);
    periodo(16'h1111, 8, 0, 1'b0);
    chk("t5_ovr_set", {31'b0, overrun}, 32'd1);
    chk("t5_newest", {16'b0, hist[0]}, 32'h0014);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("t5_ovr_clr", {31'b0, overrun}, 32'd0);
    cyc(1'b1, 16'h2222, 1'b0, 1'b1);
    chk("t5_set_wins", {31'b0, overrun}, 32'd1);
    periodo(16'h0000, 12, 100, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1);

    // T6: reset in the middle of a read-out (at tap_idx 4).
    cyc(1'b1, 16'h3333, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 16'h0000, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t6_idx4", {29'b0, tap_idx}, 32'd4);
    do_reset();
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    cyc(1'b1, 16'h0123, 1'b1, 1'b0);
    chk("t6_first", {16'b0, tap_out}, 32'h0123);
    repeat (10) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Randomized periods, backpressure and overrun clears.
    for (int p = 0; p < 60; p++) begin
      int pct;
      case ($urandom_range(0, 2))
        0:       pct = 100;
        1:       pct = 70;
        default: pct = 30;
      endcase
      periodo(ANCHO'($urandom), $urandom_range(4, 14), pct, 1'b1);
    end
    repeat (20) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
